// File: rtl/alu_pkg.sv
// Shared definitions for the RiSC-16 ALU slice: widths, function encoding,
// word type. The codebase macros `WORD_LEN / `FUNCT_LEN fall back to 16 / 2.
// Optional flag outputs are enabled with the ALU_FLAGS_EN macro.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef FUNCT_LEN
`define FUNCT_LEN 2
`endif

package alu_pkg;

    localparam int WORD_LEN  = `WORD_LEN;
    localparam int FUNCT_LEN = `FUNCT_LEN;

    typedef logic [WORD_LEN-1:0] word_t;

    // Fully decoded 2-bit function select.
    typedef enum logic [FUNCT_LEN-1:0] {
        ALU_ADD  = 2'd0,
        ALU_NAND = 2'd1,
        ALU_PASS = 2'd2,
        ALU_SUB  = 2'd3
    } alu_funct_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read side (master) and the
// ALU (slave). carry/zero exist only when ALU_FLAGS_EN is defined.
interface alu_if #(
    parameter int WORD_LEN  = `WORD_LEN,
    parameter int FUNCT_LEN = `FUNCT_LEN
);

    logic                 in_valid;
    logic [WORD_LEN-1:0]  ina;
    logic [WORD_LEN-1:0]  inb;
    logic [FUNCT_LEN-1:0] funct;
    logic [WORD_LEN-1:0]  out;
    logic                 stat;
    logic                 out_valid;
`ifdef ALU_FLAGS_EN
    logic                 carry;
    logic                 zero;

    modport master (output in_valid, ina, inb, funct,
                    input  out, stat, out_valid, carry, zero);
    modport slave  (input  in_valid, ina, inb, funct,
                    output out, stat, out_valid, carry, zero);
`else
    modport master (output in_valid, ina, inb, funct,
                    input  out, stat, out_valid);
    modport slave  (input  in_valid, ina, inb, funct,
                    output out, stat, out_valid);
`endif

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, equality status and (with ALU_FLAGS_EN)
// carry/zero flags. No state; the top level registers everything.
module alu_core #(
    parameter int WORD_LEN  = `WORD_LEN,
    parameter int FUNCT_LEN = `FUNCT_LEN
) (
    input  logic [WORD_LEN-1:0]  ina,
    input  logic [WORD_LEN-1:0]  inb,
    input  logic [FUNCT_LEN-1:0] funct,
    output logic [WORD_LEN-1:0]  res,
`ifdef ALU_FLAGS_EN
    output logic                 carry,
    output logic                 zero,
`endif
    output logic                 stat
);
    import alu_pkg::*;

    // Equality is independent of the selected function (BEQ uses it).
    assign stat = (ina == inb);

    // Function decode; SUB carry is the no-borrow indicator.
    always_comb begin
        res = '0;
`ifdef ALU_FLAGS_EN
        carry = 1'b0;
`endif
        case (alu_funct_e'(funct))
`ifdef ALU_FLAGS_EN
            ALU_ADD:  {carry, res} = {1'b0, ina} + {1'b0, inb};
            ALU_SUB:  begin
                {carry, res} = {1'b0, ina} - {1'b0, inb};
                carry = ~carry;
            end
`else
            ALU_ADD:  res = ina + inb;
            ALU_SUB:  res = ina - inb;
`endif
            ALU_NAND: res = ~(ina & inb);
            ALU_PASS: res = inb;
            default:  res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    assign zero = (res == '0);
`endif

endmodule

// File: rtl/alu.sv
// RiSC-16 ALU top: combinational core followed by one register stage with a
// valid qualifier. Data holds when no valid op arrives; valid drops.
// Optional carry/zero outputs via ALU_FLAGS_EN.
module alu #(
    parameter int WORD_LEN  = `WORD_LEN,
    parameter int FUNCT_LEN = `FUNCT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    import alu_pkg::*;

    logic [WORD_LEN-1:0] res_p0;
    logic                stat_p0;
    logic [WORD_LEN-1:0] out_p1;
    logic                stat_p1;
    logic                vld_p1;
`ifdef ALU_FLAGS_EN
    logic                carry_p0, zero_p0;
    logic                carry_p1, zero_p1;
`endif

    // Stage p0: combinational evaluation of the current operands.
    alu_core #(
        .WORD_LEN  (WORD_LEN),
        .FUNCT_LEN (FUNCT_LEN)
    ) u_core (
        .ina   (bus.ina),
        .inb   (bus.inb),
        .funct (bus.funct),
        .res   (res_p0),
`ifdef ALU_FLAGS_EN
        .carry (carry_p0),
        .zero  (zero_p0),
`endif
        .stat  (stat_p0)
    );

    // Stage p1: capture on valid ops, hold otherwise; valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1   <= '0;
            stat_p1  <= 1'b0;
            vld_p1   <= 1'b0;
`ifdef ALU_FLAGS_EN
            carry_p1 <= 1'b0;
            zero_p1  <= 1'b0;
`endif
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                out_p1   <= res_p0;
                stat_p1  <= stat_p0;
`ifdef ALU_FLAGS_EN
                carry_p1 <= carry_p0;
                zero_p1  <= zero_p0;
`endif
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.stat      = stat_p1;
    assign bus.out_valid = vld_p1;
`ifdef ALU_FLAGS_EN
    assign bus.carry     = carry_p1;
    assign bus.zero      = zero_p1;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary cases plus a randomized
// stream compared against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic logic [15:0] m_res(input int unsigned a, input int unsigned b, input int unsigned f);
        int unsigned r;
        case (f)
            0:       r = (a + b) % 65536;
            1:       r = 65535 - (a & b);
            2:       r = b;
            default: r = (a + 65536 - b) % 65536;
        endcase
        return r[15:0];
    endfunction

    function automatic logic m_carry(input int unsigned a, input int unsigned b, input int unsigned f);
        if (f == 0) return (a + b) > 65535;
        if (f == 3) return a >= b;
        return 1'b0;
    endfunction

    // Present one set of inputs for exactly one rising edge, then settle at negedge.
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
        bus.in_valid = v;
        bus.ina      = a;
        bus.inb      = b;
        bus.funct    = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        vectors++;
        if (bus.out !== 16'h0 || bus.stat !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial out=%h stat=%b vld=%b required 0000/0/0", bus.out, bus.stat, bus.out_valid);
        end
        // Reset held across an edge with in_valid=1: no result.
        drive(1'b1, 16'h0003, 16'h0003, 2'd0);
        vectors++;
        if (bus.out !== 16'h0 || bus.stat !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins out=%h stat=%b vld=%b required 0000/0/0", bus.out, bus.stat, bus.out_valid);
        end
        rst_n = 1'b1;
        drive(1'b1, 16'h1111, 16'h1111, 2'd1);
        vectors++;
        if (bus.out !== 16'hEEEE || bus.stat !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_op out=%h stat=%b vld=%b required eeee/1/1", bus.out, bus.stat, bus.out_valid);
        end
        // Mid-cycle asynchronous reset.
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out !== 16'h0 || bus.stat !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async out=%h stat=%b vld=%b required 0000/0/0", bus.out, bus.stat, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        logic [15:0] a_t [4] = '{16'd0, 16'd0, 16'd1, 16'd1};
        logic [15:0] b_t [4] = '{16'd2, 16'd1, 16'd2, 16'd1};
        logic [15:0] r_t [4] = '{16'd2, 16'd1, 16'd3, 16'd2};
        logic        s_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, a_t[i], b_t[i], 2'd0);
            vectors++;
            if (bus.out !== r_t[i] || bus.stat !== s_t[i] || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL add[%0d] out=%h stat=%b vld=%b required %h/%b/1", i, bus.out, bus.stat, bus.out_valid, r_t[i], s_t[i]);
            end
        end
    endtask

    task automatic test_nand;
        logic [15:0] a_t [4] = '{16'd0, 16'd0, 16'd1, 16'd1};
        logic [15:0] b_t [4] = '{16'd2, 16'd1, 16'd2, 16'd1};
        logic [15:0] r_t [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, a_t[i], b_t[i], 2'd1);
            vectors++;
            if (bus.out !== r_t[i] || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL nand[%0d] out=%h vld=%b required %h/1", i, bus.out, bus.out_valid, r_t[i]);
            end
        end
        drive(1'b1, 16'h0000, 16'h0000, 2'd1);
        vectors++;
        if (bus.out !== 16'hFFFF || bus.stat !== 1'b1) begin
            errors++;
            $display("FAIL nand_zero out=%h stat=%b required ffff/1", bus.out, bus.stat);
        end
    endtask

    task automatic test_boundaries;
        drive(1'b1, 16'd10, 16'hFFF6, 2'd0);
        vectors++;
        if (bus.out !== 16'h0000 || bus.stat !== 1'b0) begin
            errors++;
            $display("FAIL wrap_add out=%h stat=%b required 0000/0", bus.out, bus.stat);
        end
`ifdef ALU_FLAGS_EN
        vectors++;
        if (bus.carry !== 1'b1 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL wrap_flags carry=%b zero=%b required 1/1", bus.carry, bus.zero);
        end
`endif
        drive(1'b1, 16'hFFFF, 16'h0001, 2'd0);
        vectors++;
        if (bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL ffff_plus_1 out=%h required 0000", bus.out);
        end
        drive(1'b1, 16'h0000, 16'h0001, 2'd3);
        vectors++;
        if (bus.out !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_minus_1 out=%h required ffff", bus.out);
        end
`ifdef ALU_FLAGS_EN
        vectors++;
        if (bus.carry !== 1'b0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL borrow_flags carry=%b zero=%b required 0/0", bus.carry, bus.zero);
        end
`endif
    endtask

    task automatic test_pass_sub;
        drive(1'b1, 16'd5, 16'd5, 2'd3);
        vectors++;
        if (bus.out !== 16'h0000 || bus.stat !== 1'b1) begin
            errors++;
            $display("FAIL sub_equal out=%h stat=%b required 0000/1", bus.out, bus.stat);
        end
        drive(1'b1, 16'd7, 16'h1234, 2'd2);
        vectors++;
        if (bus.out !== 16'h1234 || bus.stat !== 1'b0) begin
            errors++;
            $display("FAIL pass_b out=%h stat=%b required 1234/0", bus.out, bus.stat);
        end
    endtask

    task automatic test_hold;
        logic [15:0] a, b, r;
        a = 16'($urandom);
        b = 16'($urandom);
        r = m_res(a, b, 0);
        drive(1'b1, a, b, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'($urandom), 16'($urandom), 2'($urandom));
            vectors++;
            if (bus.out !== r || bus.stat !== (a == b) || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] out=%h stat=%b vld=%b required %h/%b/0", i, bus.out, bus.stat, bus.out_valid, r, (a == b));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a, b, exp_r;
        logic [1:0]  f;
        logic        v, exp_s, exp_v;
`ifdef ALU_FLAGS_EN
        logic        exp_c, exp_z;
`endif
        exp_r = bus.out;
        exp_s = bus.stat;
`ifdef ALU_FLAGS_EN
        exp_c = bus.carry;
        exp_z = bus.zero;
`endif
        for (int i = 0; i < 200; i++) begin
            v = (i < 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
            f = 2'($urandom);
            if (v) begin
                exp_r = m_res(a, b, f);
                exp_s = (a == b);
`ifdef ALU_FLAGS_EN
                exp_c = m_carry(a, b, f);
                exp_z = (exp_r == 16'h0);
`endif
            end
            exp_v = v;
            drive(v, a, b, f);
            vectors++;
            if (bus.out !== exp_r || bus.stat !== exp_s || bus.out_valid !== exp_v) begin
                errors++;
                $display("FAIL rand[%0d] a=%h b=%h f=%0d v=%b out=%h stat=%b vld=%b required %h/%b/%b",
                         i, a, b, f, v, bus.out, bus.stat, bus.out_valid, exp_r, exp_s, exp_v);
            end
`ifdef ALU_FLAGS_EN
            vectors++;
            if (bus.carry !== exp_c || bus.zero !== exp_z) begin
                errors++;
                $display("FAIL rand_flags[%0d] carry=%b zero=%b required %b/%b", i, bus.carry, bus.zero, exp_c, exp_z);
            end
`endif
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.ina      = '0;
        bus.inb      = '0;
        bus.funct    = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_nand();
        test_boundaries();
        test_pass_sub();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
